// File: rtl/line_mem_responder.sv
// -----------------------------------------------------------------------------
// line_mem_responder
//
// Memory-side responder for a 512-bit cache-line port. Each request moves one
// line (8 x 64-bit words) between the requester and an internal word array
// named `mem`. Words are moved one per cycle over 8 beats after LATENCY idle
// wait cycles. Addresses whose line index is beyond the array return an error
// and never touch the array. The array is not cleared by reset, so it can be
// preloaded from outside.
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   reset       synchronous active-high reset
//   req_valid   request present
//   req_ready   responder can accept a request (IDLE and not in reset)
//   req_we      1 = line write, 0 = line read
//   req_addr    byte address, bits [5:0] ignored
//   req_wdata   write line, word k in bits [64k+63:64k]
//   resp_valid  response present
//   resp_ready  requester accepts the response
//   resp_rdata  read line (zero for writes and errors)
//   resp_err    line index out of range
// -----------------------------------------------------------------------------
module line_mem_responder #(
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [63:0]  req_addr,
    input  logic [511:0] req_wdata,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [511:0] resp_rdata,
    output logic         resp_err
);

    localparam int          LINES    = DEPTH_WORDS / 8;
    localparam int          LINE_W   = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int          IDX_W    = LINE_W + 3;
    localparam logic [57:0] LINES_58 = 58'(LINES);
    localparam logic [3:0]  LAT_LAST = 4'((LATENCY > 0) ? (LATENCY - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_BEAT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Backing store; deliberately left out of reset.
    logic [63:0] mem [DEPTH_WORDS];

    logic               r_we;
    logic               r_err;
    logic [LINE_W-1:0]  r_line;
    logic [511:0]       r_wdata;
    logic [511:0]       r_rdata;
    logic [3:0]         r_wait_cnt;
    logic [2:0]         r_beat;
    logic               r_resp_valid;
    logic               r_resp_err;

    logic               w_accept;
    logic               w_wait_done;
    logic               w_beat_last;
    logic               w_mem_we;
    logic [57:0]        w_req_line;
    logic [IDX_W-1:0]   w_word_idx;
    logic [8:0]         w_beat_bit;
    logic               w_unused_addr_lo;

    assign w_req_line       = req_addr[63:6];
    assign w_unused_addr_lo = ^req_addr[5:0];

    // req_ready is a decode of the state register gated by reset only, so
    // there is no path from resp_ready into it.
    assign req_ready   = (r_state == ST_IDLE) && !reset;
    assign w_accept    = req_valid && req_ready;
    assign w_wait_done = (r_wait_cnt == LAT_LAST);
    assign w_beat_last = (r_beat == 3'd7);
    assign w_word_idx  = {r_line, r_beat};
    assign w_beat_bit  = {r_beat, 6'd0};

    // The reset gate makes a write interrupted on beat k leave word k untouched.
    assign w_mem_we = (r_state == ST_BEAT) && r_we && !r_err && !reset;

    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_rdata;
    assign resp_err   = r_resp_err;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = (LATENCY > 0) ? ST_WAIT : ST_BEAT;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (w_wait_done) begin
                    w_next_state = ST_BEAT;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_BEAT: begin
                if (w_beat_last) begin
                    w_next_state = ST_RESP;
                end else begin
                    w_next_state = ST_BEAT;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_RESP;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Request capture, counters, read-data assembly and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we         <= 1'b0;
            r_err        <= 1'b0;
            r_line       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_wait_cnt   <= 4'd0;
            r_beat       <= 3'd0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_we       <= req_we;
                        r_err      <= (w_req_line >= LINES_58);
                        r_line     <= w_req_line[LINE_W-1:0];
                        r_wdata    <= req_wdata;
                        r_rdata    <= '0;
                        r_wait_cnt <= 4'd0;
                        r_beat     <= 3'd0;
                    end
                end
                ST_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 4'd1;
                end
                ST_BEAT: begin
                    // Error and write transfers leave rdata at zero.
                    if (!r_we && !r_err) begin
                        r_rdata[w_beat_bit +: 64] <= mem[w_word_idx];
                    end
                    r_beat <= r_beat + 3'd1;
                    if (w_beat_last) begin
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= r_err;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_resp_err   <= 1'b0;
                        r_rdata      <= '0;
                    end
                end
                default: begin
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

    // Array write port, one word per write beat.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem[w_word_idx] <= r_wdata[w_beat_bit +: 64];
        end
    end

endmodule

// File: doc/line_mem_responder.md
Name: line_mem_responder

Overview:
- Memory-side responder for the core's cache-line port.
- Serves 512-bit line reads and accepts 512-bit line writes addressed by a 64-bit byte address.
- Backed by an internal 64-bit-wide word array, accessed one word per cycle over 8 beats.
- Sits between the core/cache and main-memory contents. The core bench preloads the array with $readmemh.

Parameters:
- DEPTH_WORDS, 4096: number of 64-bit words in the internal array. Must be a multiple of 8. Lines = DEPTH_WORDS/8.
- LATENCY, 2: idle wait cycles between request accept and the first array beat. Range 0..15.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = line write, 0 = line read.
- req_addr  input  64  byte address; bits [5:0] ignored.
- req_wdata  input  512  write line; word k occupies bits [64k+63:64k].
- resp_valid  output  1  response present.
- resp_ready  input  1  requester accepts the response.
- resp_rdata  output  512  read line, same word order as req_wdata.
- resp_err  output  1  address out of range.

Behaviour:
- Reset values: req_ready=0 during the reset cycle, then 1 in IDLE. resp_valid=0, resp_rdata=0, resp_err=0, beat counter=0, wait counter=0.
- The array is NOT cleared by reset and is named mem, so the bench can preload it hierarchically.
- States:
  - IDLE
  - WAIT
  - BEAT
  - RESP
- IDLE:
  - req_ready=1.
  - A handshake (req_valid & req_ready) at edge T latches req_we, line index = req_addr[63:6], and req_wdata.
  - err = (line index >= DEPTH_WORDS/8).
  - Next state is WAIT if LATENCY>0, else BEAT.
- Outside IDLE, req_ready=0 and requests are not accepted.
- WAIT: counts LATENCY cycles, then goes to BEAT.
- BEAT:
  - 8 cycles, beat k = 0..7, touching word index line*8 + k.
  - Read: latch mem word into rdata bits [64k+63:64k].
  - Write: store wdata word k into mem.
  - If err, the array is not touched on any beat and rdata stays 0.
  - After beat 7, go to RESP.
- RESP:
  - resp_valid=1. Drive resp_rdata (read) or all zeros (write or error) and resp_err.
  - Hold all three stable until resp_ready is 1 at an edge.
  - On that edge go to IDLE and clear resp_valid.
- Timing: with accept at edge T, resp_valid first rises after edge T+LATENCY+8, i.e. it is visible in the cycle following edge T+LATENCY+8.
  - LATENCY=2 gives a 10-edge accept-to-response latency.
- A write response (resp_valid with rdata=0) is the write acknowledge. Write data is visible to any request accepted after that acknowledge.
- Back-to-back: the response handshake returns to IDLE, and req_ready=1 in the very next cycle. There is no combinational path from resp_ready to req_ready.
- resp_ready held high before RESP has no effect. resp_ready=0 in RESP stalls indefinitely with outputs stable.
- Address wrap: there is none. Any address beyond the array, including values with high bits set such as 64'hFFFF_FFFF_FFFF_FFC0, returns err.
- Reset mid-operation:
  - Return to IDLE immediately; outputs go to their reset values.
  - A write interrupted in BEAT leaves words 0..k-1 written and the rest unchanged.
  - No response is ever issued for the aborted request.

Test Plan:
1. Preload mem[8+k] = 64'h1111_0000_0000_0000 + k for k=0..7. Read addr 64'h40 -> resp_valid exactly 10 edges after accept. resp_rdata word k = 64'h1111_0000_0000_000k. resp_err=0.
2. Write addr 64'h7F (low bits ignored, line 1) with word k = 64'hA5A5_0000_0000_0000 + k, then read 64'h40 -> write ack rdata=0, err=0. Read returns the written words. mem[8..15] match.
3. Read addr 64'h8000 with DEPTH_WORDS=4096 -> resp_err=1, resp_rdata=0 after 10 edges. A write to the same address leaves all of mem unchanged.
4. Hold resp_ready=0 for 5 cycles in RESP, with req_valid asserted for a second request throughout -> resp_valid, resp_rdata and resp_err stay stable and req_ready=0. After the handshake, the second request is accepted the next cycle.
5. Assert reset during beat 3 of a write to line 2 -> next cycle is IDLE, req_ready=1, resp_valid=0. mem[16..18] hold the new data and mem[19..23] hold the old data.
6. Rerun scenario 1 with LATENCY=0 -> resp_valid 8 edges after accept, same data.
